// File: rtl/gf180mcu_fd_io__ring_seq_if.sv
// Control/status bundle between the pad-ring sequencer and its surroundings.
// The sequencer uses the slave modport; the supervising side uses master.
interface gf180mcu_fd_io__ring_seq_if #(
    parameter int NBANK = 4
);
    localparam int IW = (NBANK > 1) ? $clog2(NBANK) : 1;

    logic             START;
    logic [NBANK-1:0] PG;
    logic [NBANK-1:0] BANK_EN;
    logic [NBANK-1:0] IO_EN;
    logic             BUSY;
    logic             DONE;
    logic             FAULT;
    logic [IW-1:0]    FAULT_BANK;

    modport master (
        output START,
        output PG,
        input  BANK_EN,
        input  IO_EN,
        input  BUSY,
        input  DONE,
        input  FAULT,
        input  FAULT_BANK
    );

    modport slave (
        input  START,
        input  PG,
        output BANK_EN,
        output IO_EN,
        output BUSY,
        output DONE,
        output FAULT,
        output FAULT_BANK
    );
endinterface

// File: rtl/gf180mcu_fd_io__ring_seq.sv
// gf180mcu pad-ring power-up sequencer: brings banks up one at a time, drops all on PG loss.
// Optional WAIT_PG timeout is enabled by defining GF180MCU_FD_IO__RING_SEQ_TIMEOUT_EN.
module gf180mcu_fd_io__ring_seq #(
    parameter int NBANK  = 4,
    parameter int SETTLE = 16,
    parameter int TMO    = 255
) (
    input logic                      CLK,
    input logic                      RST,
    gf180mcu_fd_io__ring_seq_if.slave bus
);
    localparam int IW   = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int MAXC = (SETTLE > TMO) ? SETTLE : TMO;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FLT    = 3'd4;

    logic [NBANK-1:0] pg_s1_q;
    logic [NBANK-1:0] pg_s_q;

    logic [2:0]       state_q,   state_d;
    logic [IW-1:0]    idx_q,     idx_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [NBANK-1:0] bank_en_q, bank_en_d;
    logic [NBANK-1:0] io_en_q,   io_en_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             fault_q,   fault_d;
    logic [IW-1:0]    fbank_q,   fbank_d;

    logic [NBANK-1:0] cur_oh;
    logic [NBANK-1:0] nxt_oh;
    logic [NBANK-1:0] below_mask;
    logic [NBANK-1:0] lost_below;
    logic [NBANK-1:0] lost_any;
    logic             pg_cur;
    logic             last_bank;

    function automatic logic [IW-1:0] lowest(input logic [NBANK-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int j = NBANK - 1; j >= 0; j--) begin
            if (v[j]) r = IW'(j);
        end
        return r;
    endfunction

    // PG is asynchronous to CLK; only the synchronized copy is used.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pg_s1_q <= '0;
            pg_s_q  <= '0;
        end else begin
            pg_s1_q <= bus.PG;
            pg_s_q  <= pg_s1_q;
        end
    end

    assign cur_oh     = NBANK'(1) << idx_q;
    assign nxt_oh     = NBANK'(2) << idx_q;
    assign below_mask = cur_oh - NBANK'(1);
    assign lost_below = ~pg_s_q & below_mask;
    assign lost_any   = ~pg_s_q;
    assign pg_cur     = |(pg_s_q & cur_oh);
    assign last_bank  = (idx_q == IW'(NBANK - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        bank_en_d = bank_en_q;
        io_en_d   = io_en_q;
        busy_d    = busy_q;
        done_d    = done_q;
        fault_d   = fault_q;
        fbank_d   = fbank_q;

        unique case (state_q)
            S_IDLE: begin
                bank_en_d = '0;
                io_en_d   = '0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                fault_d   = 1'b0;
                if (bus.START) begin
                    state_d   = S_WAIT;
                    idx_d     = '0;
                    cnt_d     = '0;
                    bank_en_d = NBANK'(1);
                    busy_d    = 1'b1;
                end
            end

            S_WAIT: begin
                if (|lost_below) begin
                    state_d   = S_FLT;
                    fbank_d   = lowest(lost_below);
                    bank_en_d = '0;
                    io_en_d   = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b0;
                    fault_d   = 1'b1;
                end else if (pg_cur) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
`ifdef GF180MCU_FD_IO__RING_SEQ_TIMEOUT_EN
                end else if (cnt_q == CW'(TMO - 1)) begin
                    state_d   = S_FLT;
                    fbank_d   = idx_q;
                    bank_en_d = '0;
                    io_en_d   = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b0;
                    fault_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end

            S_SETTLE: begin
                // Losing an already-released bank outranks everything here.
                if (|lost_below) begin
                    state_d   = S_FLT;
                    fbank_d   = lowest(lost_below);
                    bank_en_d = '0;
                    io_en_d   = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b0;
                    fault_d   = 1'b1;
                end else if (!pg_cur) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(SETTLE - 1)) begin
                    io_en_d = io_en_q | cur_oh;
                    cnt_d   = '0;
                    if (last_bank) begin
                        state_d = S_RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_WAIT;
                        idx_d     = idx_q + IW'(1);
                        bank_en_d = bank_en_q | nxt_oh;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_RUN: begin
                if (|lost_any) begin
                    state_d   = S_FLT;
                    fbank_d   = lowest(lost_any);
                    bank_en_d = '0;
                    io_en_d   = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b0;
                    fault_d   = 1'b1;
                end
            end

            S_FLT: begin
                bank_en_d = '0;
                io_en_d   = '0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                if (bus.START) begin
                    state_d   = S_WAIT;
                    idx_d     = '0;
                    cnt_d     = '0;
                    bank_en_d = NBANK'(1);
                    busy_d    = 1'b1;
                    fault_d   = 1'b0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                idx_d     = '0;
                cnt_d     = '0;
                bank_en_d = '0;
                io_en_d   = '0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                fault_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            bank_en_q <= '0;
            io_en_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            fbank_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            bank_en_q <= bank_en_d;
            io_en_q   <= io_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
            fbank_q   <= fbank_d;
        end
    end

    assign bus.BANK_EN    = bank_en_q;
    assign bus.IO_EN      = io_en_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.FAULT      = fault_q;
    assign bus.FAULT_BANK = fbank_q;

endmodule
